// File: rtl/kyber_bram_seq.sv
// Moves up to MAX_WORDS words between BRAM port B and the wide core vectors, one address per cycle.
// Store finishes one cycle after the last write, load RD_LAT cycles later; start is ignored while busy.
module kyber_bram_seq #(
  parameter int DATA_W    = 128,
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 50,
  parameter int CNT_W     = 6,
  parameter int RD_LAT    = 2
) (
  input  logic                          bram_clk_a,
  input  logic                          bram_rst_a,
  input  logic                          start,
  input  logic                          dir,
  input  logic [ADDR_W-1:0]             base_addr,
  input  logic [CNT_W-1:0]              num_words,
  input  logic                          abort,
  input  logic [DATA_W*MAX_WORDS-1:0]   vec_in,
  input  logic [DATA_W-1:0]             bram_rddata,
  output logic [ADDR_W-1:0]             bram_addr,
  output logic                          bram_en,
  output logic                          bram_we,
  output logic [DATA_W-1:0]             bram_wrdata,
  output logic [DATA_W*MAX_WORDS-1:0]   vec_out,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_e;

  localparam logic [RD_LAT-1:0] HEAD = RD_LAT'(1) << (RD_LAT - 1);

  state_e             state_q;
  logic               dir_q;
  logic [CNT_W-1:0]   num_q;
  logic [CNT_W-1:0]   k_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               en_q;
  logic               we_q;
  logic [DATA_W-1:0]  wrdata_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;

  logic [RD_LAT-1:0]  pvld_q;
  logic [CNT_W-1:0]   pidx_q [RD_LAT];
  logic [DATA_W-1:0]  vout_q [MAX_WORDS];
  logic [DATA_W-1:0]  vin_w  [MAX_WORDS];

  logic [31:0]        end_w;
  logic               req_bad;
  logic               in_xfer;
  logic               rd_issue;
  logic               pend;
  logic               last_k;
  logic [CNT_W-1:0]   k_d;
  logic [DATA_W-1:0]  wrdata_d;

  for (genvar i = 0; i < MAX_WORDS; i++) begin : g_words
    assign vin_w[i] = vec_in[i*DATA_W +: DATA_W];
    assign vec_out[i*DATA_W +: DATA_W] = vout_q[i];
  end

  // Reject zero, oversize and any request whose last word would wrap past the top address.
  assign end_w    = 32'(base_addr) + 32'(num_words);
  assign req_bad  = (num_words == '0) || (32'(num_words) > 32'(MAX_WORDS)) ||
                    (end_w > (32'd1 << ADDR_W));
  assign in_xfer  = (state_q == ISSUE) || (state_q == DRAIN);
  assign rd_issue = (state_q == ISSUE) && !dir_q && !abort;
  assign pend     = |(pvld_q & ~HEAD);
  assign last_k   = (k_q == num_q - CNT_W'(1));
  assign k_d      = k_q + CNT_W'(1);

  always_comb begin
    wrdata_d = '0;
    if (dir_q && (k_d < CNT_W'(MAX_WORDS))) wrdata_d = vin_w[k_d];
  end

  always_ff @(posedge bram_clk_a or posedge bram_rst_a) begin
    if (bram_rst_a) begin
      state_q  <= IDLE;
      dir_q    <= 1'b0;
      num_q    <= '0;
      k_q      <= '0;
      addr_q   <= '0;
      en_q     <= 1'b0;
      we_q     <= 1'b0;
      wrdata_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            if (req_bad) begin
              err_q <= 1'b1;
            end else begin
              state_q  <= ISSUE;
              dir_q    <= dir;
              num_q    <= num_words;
              k_q      <= '0;
              addr_q   <= base_addr;
              en_q     <= 1'b1;
              we_q     <= dir;
              wrdata_q <= dir ? vin_w[0] : '0;
              busy_q   <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (abort) begin
            state_q  <= IDLE;
            en_q     <= 1'b0;
            we_q     <= 1'b0;
            wrdata_q <= '0;
            busy_q   <= 1'b0;
          end else if (last_k) begin
            en_q     <= 1'b0;
            we_q     <= 1'b0;
            wrdata_q <= '0;
            if (dir_q) begin
              state_q <= FIN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= DRAIN;
            end
          end else begin
            k_q      <= k_d;
            addr_q   <= addr_q + ADDR_W'(1);
            wrdata_q <= wrdata_d;
          end
        end
        DRAIN: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (!pend) begin
            state_q <= FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read-return tracking: the head stage lines up with bram_rddata for the word it names.
  always_ff @(posedge bram_clk_a or posedge bram_rst_a) begin
    if (bram_rst_a) begin
      pvld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) pidx_q[i] <= '0;
      for (int w = 0; w < MAX_WORDS; w++) vout_q[w] <= '0;
    end else begin
      if (pvld_q[RD_LAT-1] && (pidx_q[RD_LAT-1] < CNT_W'(MAX_WORDS)))
        vout_q[pidx_q[RD_LAT-1]] <= bram_rddata;
      for (int i = RD_LAT - 1; i > 0; i--) begin
        pvld_q[i] <= pvld_q[i-1];
        pidx_q[i] <= pidx_q[i-1];
      end
      pvld_q[0] <= rd_issue;
      pidx_q[0] <= k_q;
      if (in_xfer && abort) pvld_q <= '0;
    end
  end

  assign bram_addr   = addr_q;
  assign bram_en     = en_q;
  assign bram_we     = we_q;
  assign bram_wrdata = wrdata_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule
